// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the mapping from the ALU function field to an operation.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MULDIV_MULT  = 2'b00,
        MULDIV_MULTU = 2'b01,
        MULDIV_DIV   = 2'b10,
        MULDIV_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    function automatic op_t funct_to_op(input logic [5:0] funct);
        op_t o;
        case (funct)
            FUNCT_MULTU: o = MULDIV_MULTU;
            FUNCT_DIV:   o = MULDIV_DIV;
            FUNCT_DIVU:  o = MULDIV_DIVU;
            default:     o = MULDIV_MULT;
        endcase
        return o;
    endfunction

    function automatic logic op_is_div(input op_t o);
        return (o == MULDIV_DIV) || (o == MULDIV_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_t o);
        return (o == MULDIV_MULT) || (o == MULDIV_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// One unsigned restoring-divide step: shift in the next dividend bit, subtract
// the divisor when it fits, and emit the quotient bit. Purely combinational.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic             q_bit,
    output logic [WIDTH-1:0] rem_out
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // rem_in < divisor, so whenever the subtraction applies the true result fits WIDTH bits.
    assign shifted = {rem_in, dividend_bit};
    assign diff    = shifted[WIDTH-1:0] - divisor;
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with start/busy/done handshake and flush cancel.
// Iterative ops finish WIDTH+2 edges after accept; single-cycle multiply and divide-by-zero after 2.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_ITER = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    op_t              op_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] rem;
    logic             neg_q;
    logic             neg_r;

    op_t              op_in;
    logic             in_signed;
    logic             in_div;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign op_in     = op_t'(op);
    assign in_signed = op_is_signed(op_in);
    assign in_div    = op_is_div(op_in);
    assign abs_a     = (in_signed && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (in_signed && b[WIDTH-1]) ? -b : b;

    logic             q_bit;
    logic [WIDTH-1:0] rem_next;

    div_core #(.WIDTH(WIDTH)) u_div_core (
        .rem_in       (rem),
        .dividend_bit (qr[WIDTH-1]),
        .divisor      (mag_b),
        .q_bit        (q_bit),
        .rem_out      (rem_next)
    );

    // Shift-add multiply: rem holds the running high half, qr the multiplier shifting out.
    logic [WIDTH:0] add_sum;
    assign add_sum = {1'b0, rem} + (qr[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});

    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rmd;

    always_comb begin
        prod_mag = '0;
        if (MUL_ITER != 0) begin
            prod_mag = {rem, qr};
        end else begin
            prod_mag = {{WIDTH{1'b0}}, qr} * {{WIDTH{1'b0}}, mag_b};
        end
        prod = neg_q ? -prod_mag : prod_mag;
        quo  = neg_q ? -qr : qr;
        rmd  = neg_r ? -rem : rem;
    end

    assign busy = (state == CALC) || (state == FIX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            op_r  <= MULDIV_MULT;
            cnt   <= '0;
            qr    <= '0;
            mag_b <= '0;
            rem   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            op_r  <= op_in;
                            cnt   <= '0;
                            rem   <= '0;
                            mag_b <= abs_b;
                            neg_q <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r <= in_signed & in_div & a[WIDTH-1];
                            // A zero divisor keeps the raw dividend so it can be returned in hi.
                            qr    <= (in_div && (b == '0)) ? a : abs_a;
                            if (in_div) begin
                                state <= (b == '0) ? FIX : CALC;
                            end else begin
                                state <= (MUL_ITER != 0) ? CALC : FIX;
                            end
                        end
                    end
                    CALC: begin
                        if (op_is_div(op_r)) begin
                            rem <= rem_next;
                            qr  <= {qr[WIDTH-2:0], q_bit};
                        end else begin
                            rem <= add_sum[WIDTH:1];
                            qr  <= {add_sum[0], qr[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        done  <= 1'b1;
                        state <= IDLE;
                        if (op_is_div(op_r)) begin
                            if (mag_b == '0) begin
                                lo  <= '1;
                                hi  <= qr;
                                dbz <= 1'b1;
                            end else begin
                                lo  <= quo;
                                hi  <= rmd;
                                dbz <= 1'b0;
                            end
                        end else begin
                            hi  <= prod[2*WIDTH-1:WIDTH];
                            lo  <= prod[WIDTH-1:0];
                            dbz <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: one instance with single-cycle multiply and one iterative.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;

    logic        busy0, done0, dbz0, busy1, done1, dbz1;
    logic [31:0] hi0, lo0, hi1, lo1;

    int total = 0;
    int bad = 0;

    int          lat0, lat1, bcnt;
    logic [31:0] r_hi0, r_lo0, r_hi1, r_lo1;
    logic        r_dbz0, r_dbz1;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .MUL_ITER(0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
        .busy(busy0), .done(done0), .hi(hi0), .lo(lo0), .dbz(dbz0)
    );

    muldiv_unit #(.WIDTH(32), .MUL_ITER(1)) u_dut_it (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
        .busy(busy1), .done(done1), .hi(hi1), .lo(lo1), .dbz(dbz1)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drives a request so it is accepted at the next rising edge, then follows both
    // instances until each has pulsed done (edge counts are relative to the accept edge).
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        lat0 = 0; lat1 = 0; bcnt = 0;
        for (int n = 1; n <= 60 && (lat0 == 0 || lat1 == 0); n++) begin
            if (n > 1) begin
                @(posedge clk); #1;
            end
            if (busy0) bcnt++;
            if (done0 && lat0 == 0) begin
                lat0 = n; r_hi0 = hi0; r_lo0 = lo0; r_dbz0 = dbz0;
            end
            if (done1 && lat1 == 0) begin
                lat1 = n; r_hi1 = hi1; r_lo1 = lo1; r_dbz1 = dbz1;
            end
        end
    endtask

    initial begin
        int seen;
        #1;
        check_val("rst_hi", hi0, 32'h0);
        check_val("rst_lo", lo0, 32'h0);
        check_val("rst_done_busy_dbz", {done0, busy0, dbz0}, 3'b000);
        @(negedge clk); rst = 1'b1;

        // Signed divide with negative dividend: -7 / 2 = -3 rem -1
        @(negedge clk);
        run_op(MULDIV_DIV, 32'hFFFF_FFF9, 32'd2);
        check_val("div_lat", lat0, 34);
        check_val("div_busy_cycles", bcnt, 33);
        check_val("div_busy_at_done", busy0, 1'b0);
        check_val("div_lo", r_lo0, 32'hFFFF_FFFD);
        check_val("div_hi", r_hi0, 32'hFFFF_FFFF);
        check_val("div_dbz", r_dbz0, 1'b0);
        check_val("div_it_lo", r_lo1, 32'hFFFF_FFFD);

        // Unsigned divide, then most-negative / -1 started in the done cycle
        @(negedge clk);
        run_op(MULDIV_DIVU, 32'hFFFF_FFFF, 32'h10);
        check_val("divu_lo", r_lo0, 32'h0FFF_FFFF);
        check_val("divu_hi", r_hi0, 32'hF);
        run_op(MULDIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check_val("b2b_lat", lat0, 34);
        check_val("minneg_lo", r_lo0, 32'h8000_0000);
        check_val("minneg_hi", r_hi0, 32'h0);

        // Multiplies on both instances
        @(negedge clk);
        run_op(MULDIV_MULT, 32'hFFFF_FFFF, 32'd2);
        check_val("mult_lat", lat0, 2);
        check_val("mult_it_lat", lat1, 34);
        check_val("mult_res", {r_hi0, r_lo0}, 64'hFFFF_FFFF_FFFF_FFFE);
        check_val("mult_it_res", {r_hi1, r_lo1}, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        run_op(MULDIV_MULTU, 32'hFFFF_FFFF, 32'd2);
        check_val("multu_res", {r_hi0, r_lo0}, 64'h0000_0001_FFFF_FFFE);
        check_val("multu_it_res", {r_hi1, r_lo1}, 64'h0000_0001_FFFF_FFFE);
        check_val("multu_it_lat", lat1, 34);

        // Divide by zero
        @(negedge clk);
        run_op(MULDIV_DIV, 32'h1234, 32'h0);
        check_val("dbz_lat", lat0, 2);
        check_val("dbz_lo", r_lo0, 32'hFFFF_FFFF);
        check_val("dbz_hi", r_hi0, 32'h1234);
        check_val("dbz_flag", r_dbz0, 1'b1);

        // Cancel at edge 10 together with a new start
        @(negedge clk);
        start = 1'b1; op = MULDIV_DIVU; a = 32'd5000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        cancel = 1'b1; start = 1'b1; op = MULDIV_DIVU; a = 32'd77; b = 32'd5;
        @(posedge clk); #1;
        cancel = 1'b0; start = 1'b0;
        check_val("cancel_busy", {busy0, busy1}, 2'b00);
        check_val("cancel_done", {done0, done1}, 2'b00);
        check_val("cancel_hi", hi0, 32'h1234);
        check_val("cancel_lo", lo0, 32'hFFFF_FFFF);
        check_val("cancel_dbz", dbz0, 1'b1);
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done0 || done1 || busy0 || busy1) seen++;
        end
        check_val("cancel_quiet", seen, 0);
        @(negedge clk);
        run_op(MULDIV_DIVU, 32'd100, 32'd7);
        check_val("fresh_lo", r_lo0, 32'd14);
        check_val("fresh_hi", r_hi0, 32'd2);
        check_val("fresh_dbz", r_dbz0, 1'b0);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = MULDIV_DIV; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (13) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("arst_hilo", {hi0, lo0}, 64'h0);
        check_val("arst_it_hilo", {hi1, lo1}, 64'h0);
        check_val("arst_flags", {done0, busy0, dbz0, busy1}, 4'b0000);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        run_op(MULDIV_MULTU, 32'd3, 32'd5);
        check_val("post_rst_res", {r_hi0, r_lo0}, 64'd15);
        check_val("post_rst_it_res", {r_hi1, r_lo1}, 64'd15);
        check_val("post_rst_lat", lat0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
